// File: rtl/vehicle_sensor_conditioner.sv
// Vehicle sensor conditioner for a country-road loop detector.
//
// Synchronizes and debounces the raw loop input, then qualifies it into a
// vehicle-present request for the signal controller. The request is stretched
// for HOLD cycles after the vehicle leaves. A loop that reads "present" for too
// long is flagged as stuck, and the request is dropped until it releases.
// Vehicle arrivals are counted with saturation.
//
// Parameters:
//   DEBOUNCE    (1..15)    cycles a new synchronized level must persist
//   HOLD        (1..255)   cycles X stays high after the debounced release
//   STUCK_LIMIT (1..65535) cycles of continuous presence before a fault
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   sense_raw  in   asynchronous loop detector, 1 = vehicle over loop
//   count_clr  in   synchronous clear of veh_count
//   X          out  qualified vehicle-present request
//   det        out  debounced sensor level
//   fault      out  stuck-sensor indication
//   veh_count  out  vehicles detected since last clear/reset (saturating)
module vehicle_sensor_conditioner #(
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned HOLD        = 8,
  parameter int unsigned STUCK_LIMIT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_raw,
  input  logic       count_clr,
  output logic       X,
  output logic       det,
  output logic       fault,
  output logic [7:0] veh_count
);

  localparam logic [3:0]  DebLast   = 4'(DEBOUNCE - 1);
  localparam logic [7:0]  HoldInit  = 8'(HOLD - 1);
  localparam logic [15:0] StuckLast = 16'(STUCK_LIMIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPresent,
    StHold,
    StFault
  } state_e;

  logic        s1_q, s2_q;
  logic        det_q, det_d;
  logic [3:0]  deb_cnt_q, deb_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] stuck_cnt_q, stuck_cnt_d;
  logic [7:0]  cnt_q, cnt_d;
  state_e      state_q, state_d;
  logic        det_rise;

  // Debounce: count consecutive disagreeing samples; the cycle the count would
  // reach DEBOUNCE the level is accepted and the count restarts.
  always_comb begin
    det_d     = det_q;
    deb_cnt_d = '0;
    if (s2_q != det_q) begin
      if (deb_cnt_q == DebLast) begin
        det_d = ~det_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 4'd1;
      end
    end
  end

  assign det_rise = det_d & ~det_q;

  // Counting follows the debounced level directly, independent of FSM state.
  // Clear wins over a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (det_rise && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stuck_cnt_d = stuck_cnt_q;
    case (state_q)
      StIdle: begin
        if (det_q) begin
          state_d     = StPresent;
          stuck_cnt_d = '0;
        end
      end
      StPresent: begin
        if (!det_q) begin
          state_d    = StHold;
          hold_cnt_d = HoldInit;
        end else if (stuck_cnt_q == StuckLast) begin
          state_d = StFault;
        end else begin
          stuck_cnt_d = stuck_cnt_q + 16'd1;
        end
      end
      StHold: begin
        // Retrigger is checked first so a returning vehicle on the expiry
        // cycle never lets X drop.
        if (det_q) begin
          state_d     = StPresent;
          stuck_cnt_d = '0;
        end else if (hold_cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      StFault: begin
        if (!det_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      det_q       <= 1'b0;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      stuck_cnt_q <= '0;
      cnt_q       <= '0;
      state_q     <= StIdle;
    end else begin
      s1_q        <= sense_raw;
      s2_q        <= s1_q;
      det_q       <= det_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
    end
  end

  assign X         = (state_q == StPresent) || (state_q == StHold);
  assign fault     = (state_q == StFault);
  assign det       = det_q;
  assign veh_count = cnt_q;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Bench for vehicle_sensor_conditioner. Two instances share one stimulus
// stream: one with default parameters and one with a short stuck limit.
// The reference model describes behaviour in terms of sample histories:
//   det flips once the last DEBOUNCE synchronized samples all disagree with it;
//   X is high while some det=1 sample lies within the last HOLD+1 edges,
//   unless the current presence run was declared stuck;
//   stuck is declared when det has been sampled high STUCK_LIMIT+1 edges in a
//   row, and the block is lifted by the next fresh arrival.
module tb_vehicle_sensor_conditioner;

  localparam int Deb  = 4;
  localparam int Hold = 8;
  localparam int LimA = 200;
  localparam int LimB = 10;
  localparam int Far  = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sense_raw = 1'b0;
  logic       count_clr = 1'b0;
  logic       x_a, det_a, fault_a, x_b, det_b, fault_b;
  logic [7:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  vehicle_sensor_conditioner u_dflt (
    .clk      (clk),
    .rst      (rst),
    .sense_raw(sense_raw),
    .count_clr(count_clr),
    .X        (x_a),
    .det      (det_a),
    .fault    (fault_a),
    .veh_count(cnt_a)
  );

  vehicle_sensor_conditioner #(
    .DEBOUNCE   (Deb),
    .HOLD       (Hold),
    .STUCK_LIMIT(LimB)
  ) u_stuck (
    .clk      (clk),
    .rst      (rst),
    .sense_raw(sense_raw),
    .count_clr(count_clr),
    .X        (x_b),
    .det      (det_b),
    .fault    (fault_b),
    .veh_count(cnt_b)
  );

  typedef struct packed {
    logic       x;
    logic       det;
    logic       fault;
    logic [7:0] cnt;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  typedef struct {
    logic        s1;
    logic        s2;
    logic [15:0] hist;       // synchronized samples, bit 0 = newest
    logic        det;
    int          cnt;
    int          run;        // consecutive edges that sampled det = 1
    int          since_high; // edges since det was last sampled high
    logic        blocked;    // current presence run was declared stuck
  } mdl_t;

  exp_t exp_q[$];
  exp_t mon_e;
  mdl_t ma, mb;
  int   checks = 0;
  int   errors = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic mdl_step(input mdl_t mi, input int limit, input logic raw, input logic clr,
                          input logic rs, output mdl_t mo, output obs_t o);
    logic all_other;
    mo = mi;
    if (rs) begin
      mo.s1         = 1'b0;
      mo.s2         = 1'b0;
      mo.hist       = '0;
      mo.det        = 1'b0;
      mo.cnt        = 0;
      mo.run        = 0;
      mo.since_high = Far;
      mo.blocked    = 1'b0;
    end else begin
      mo.run        = mi.det ? mi.run + 1 : 0;
      mo.since_high = mi.det ? 0 : ((mi.since_high >= Far) ? Far : mi.since_high + 1);
      if (mi.det && (mo.run == 1)) mo.blocked = 1'b0;
      if (mo.run == limit + 1) mo.blocked = 1'b1;
      mo.hist   = {mi.hist[14:0], mi.s2};
      all_other = 1'b1;
      for (int i = 0; i < Deb; i++) begin
        if (mo.hist[i] == mi.det) all_other = 1'b0;
      end
      if (all_other) begin
        mo.det = ~mi.det;
        if (mo.det && (mo.cnt < 255)) mo.cnt = mo.cnt + 1;
      end
      if (clr) mo.cnt = 0;
      mo.s2 = mi.s1;
      mo.s1 = raw;
    end
    o.det   = mo.det;
    o.cnt   = 8'(mo.cnt);
    o.fault = mo.blocked && (mo.run > 0);
    o.x     = !mo.blocked && (mo.since_high <= Hold);
  endtask

  // One clock: drive at the falling edge, predict, then wait for the edge.
  task automatic tick(input logic raw, input logic clr, input logic rs);
    exp_t e;
    mdl_t na, nb;
    @(negedge clk);
    sense_raw = raw;
    count_clr = clr;
    rst       = rs;
    mdl_step(ma, LimA, raw, clr, rs, na, e.a);
    mdl_step(mb, LimB, raw, clr, rs, nb, e.b);
    ma = na;
    mb = nb;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic vehicle(input int hi, input int lo);
    repeat (hi) tick(1'b1, 1'b0, 1'b0);
    repeat (lo) tick(1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every edge produces an output sample to compare.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("a.X", int'(x_a), int'(mon_e.a.x));
      check("a.det", int'(det_a), int'(mon_e.a.det));
      check("a.fault", int'(fault_a), int'(mon_e.a.fault));
      check("a.veh_count", int'(cnt_a), int'(mon_e.a.cnt));
      check("b.X", int'(x_b), int'(mon_e.b.x));
      check("b.det", int'(det_b), int'(mon_e.b.det));
      check("b.fault", int'(fault_b), int'(mon_e.b.fault));
      check("b.veh_count", int'(cnt_b), int'(mon_e.b.cnt));
    end
  end

  initial begin
    int   base;
    int   total;
    int   len;
    logic seen;
    logic nodrop;
    logic lvl;

    repeat (3) tick(1'b0, 1'b0, 1'b1);
    #1;
    check("reset X", int'(x_a), 0);
    check("reset veh_count", int'(cnt_a), 0);

    // Held arrival: det at edge 6, X at edge 7.
    for (int e = 1; e <= 25; e++) begin
      tick(1'b1, 1'b0, 1'b0);
      #1;
      if (e == 5) check("det before edge 6", int'(det_a), 0);
      if (e == 6) check("det at edge 6", int'(det_a), 1);
      if (e == 6) check("X at edge 6", int'(x_a), 0);
      if (e == 6) check("count at edge 6", int'(cnt_a), 1);
      if (e == 7) check("X at edge 7", int'(x_a), 1);
      if (e == 16) check("b fault before limit", int'(fault_b), 0);
      if (e == 17) check("b fault at limit", int'(fault_b), 1);
      if (e == 17) check("b X in fault", int'(x_b), 0);
    end
    check("a no fault", int'(fault_a), 0);

    // Release: det falls at edge 31, X holds through edge 39.
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      #1;
      if (i == 14) check("X held in hold", int'(x_a), 1);
      if (i == 15) check("X after hold", int'(x_a), 0);
    end
    check("b fault cleared", int'(fault_b), 0);

    // Fresh arrival on the faulted instance raises X again.
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick((i < 6) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      #1;
      seen = seen | x_b;
    end
    check("b X after fault", int'(seen), 1);

    // Short glitches never change det or the count.
    base = int'(cnt_a);
    seen = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      for (int i = 0; i < p + 5; i++) begin
        tick((i < p) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        #1;
        seen = seen | det_a;
      end
    end
    repeat (4) begin
      tick(1'b0, 1'b0, 1'b0);
      #1;
      seen = seen | det_a;
    end
    check("glitch det", int'(seen), 0);
    check("glitch count", int'(cnt_a), base);

    // Retrigger exactly on the expiry cycle keeps X high.
    base = int'(cnt_a);
    vehicle(10, 0);
    nodrop = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick((i < 8) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      #1;
      nodrop = nodrop & x_a;
    end
    check("retrigger X", int'(nodrop), 1);
    check("retrigger count", int'(cnt_a) - base, 2);
    vehicle(0, 20);

    // Gap sweep around the hold window.
    for (int l = 4; l <= 12; l++) vehicle(6, l);
    vehicle(0, 20);

    // Saturation.
    for (int v = 0; v < 300; v++) vehicle($urandom_range(5, 12), $urandom_range(5, 14));
    check("saturate a", int'(cnt_a), 255);
    check("saturate b", int'(cnt_b), 255);

    // Clear coincident with det rise; also a sensor already high out of reset.
    repeat (2) tick(1'b1, 1'b0, 1'b1);
    for (int e = 1; e <= 6; e++) tick(1'b1, (e == 6) ? 1'b1 : 1'b0, 1'b0);
    #1;
    check("clr vs rise det", int'(det_a), 1);
    check("clr vs rise count", int'(cnt_a), 0);
    vehicle(4, 20);
    vehicle(6, 20);
    check("count after clr", int'(cnt_a), 1);

    // Reset while in HOLD (a) and FAULT (b).
    vehicle(8, 6);
    #1;
    check("in hold X", int'(x_a), 1);
    tick(1'b0, 1'b0, 1'b1);
    #1;
    check("rst hold X", int'(x_a), 0);
    check("rst hold det", int'(det_a), 0);
    check("rst hold count", int'(cnt_a), 0);
    vehicle(25, 0);
    #1;
    check("pre-rst b fault", int'(fault_b), 1);
    tick(1'b1, 1'b0, 1'b1);
    #1;
    check("rst fault", int'(fault_b), 0);
    check("rst fault det", int'(det_b), 0);
    vehicle(10, 20);

    // Random runs with occasional clears and resets.
    total = 0;
    lvl   = 1'b0;
    while (total < 2000) begin
      len = $urandom_range(1, 15);
      lvl = ~lvl;
      repeat (len) tick(lvl, ($urandom_range(0, 29) == 0), ($urandom_range(0, 499) == 0));
      total = total + len;
    end

    repeat (3) tick(1'b0, 1'b0, 1'b0);
    #2;
    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
